// File: rtl/lock_pkg.sv
// lock_pkg
//   Shared types and helpers for the key loader in front of the XOR-locked
//   8x8 multiplier.
//   - lk_state_t : loader FSM state encoding
//   - KEY_BYTES  : number of key bytes for the default 64-bit key
//   - xor_fold8  : folds a 64-bit key into its 8-bit XOR checksum
package lock_pkg;

  typedef enum logic [2:0] {
    LK_IDLE  = 3'd0,
    LK_LOAD  = 3'd1,
    LK_CHECK = 3'd2,
    LK_ARMED = 3'd3,
    LK_ERROR = 3'd4
  } lk_state_t;

  localparam int KEY_W_DEF = 64;
  localparam int KEY_BYTES = KEY_W_DEF / 8;

  function automatic logic [7:0] xor_fold8(input logic [KEY_W_DEF-1:0] key);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < KEY_BYTES; i++) begin
      acc = acc ^ key[8*i +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/lock_key_shreg.sv
// lock_key_shreg
//   Byte-wide shadow shift register with a running XOR accumulator.
//   Bytes enter at the LSB end so the first byte ends up in the MSB byte.
// Ports:
//   clk_i    : clock
//   rst_i    : asynchronous reset, active-high
//   clear_i  : synchronous clear of shadow and accumulator
//   shift_i  : shift byte_i in and fold it into the accumulator
//   byte_i   : incoming key byte
//   shadow_o : shadow key (never visible downstream until verified)
//   acc_o    : XOR of all bytes shifted in since the last clear
module lock_key_shreg #(
  parameter int KEY_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic [7:0]       byte_i,
  output logic [KEY_W-1:0] shadow_o,
  output logic [7:0]       acc_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_o <= '0;
      acc_o    <= '0;
    end else if (clear_i) begin
      shadow_o <= '0;
      acc_o    <= '0;
    end else if (shift_i) begin
      shadow_o <= {shadow_o[KEY_W-9:0], byte_i};
      acc_o    <= acc_o ^ byte_i;
    end
  end

endmodule

// File: rtl/lock_key_loader.sv
// lock_key_loader
//   Receives a key as a byte stream (MSB byte first) followed by an XOR
//   checksum byte, and commits it to key_o only after the checksum matches.
//   key_o stays all-zero whenever no verified key is held.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | no session, no key
//   LOAD     | accepting key bytes then the checksum byte
//   CHECK    | one cycle: commit key or flag error
//   ARMED    | verified key on key_o, input ignored
//   ERROR    | last session failed, wait for start/clear
//
// Ports:
//   clk_i, rst_i        : clock, async active-high reset
//   start_i, clear_i    : begin new session / wipe key and go idle
//   byte_i, byte_valid_i, byte_ready_o : byte stream handshake
//   key_o, key_valid_o  : committed key and its valid flag
//   busy_o, error_o     : session in progress / last session failed
module lock_key_loader
  import lock_pkg::*;
#(
  parameter int KEY_W   = 64,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid_o,
  output logic             busy_o,
  output logic             error_o
);

  localparam int N_BYTES = KEY_W / 8;
  localparam int CW      = $clog2(N_BYTES + 1);
  localparam int TW      = $clog2(TIMEOUT + 1);

  lk_state_t        state;
  logic [CW-1:0]    byte_cnt;
  logic [TW-1:0]    timer;
  logic             chk_ok;
  logic [KEY_W-1:0] shadow;
  logic [7:0]       acc;

  logic accept;
  logic is_cs_byte;
  logic sh_clear;
  logic sh_shift;

  // byte_ready_o is only ever 1 in LOAD; a start/clear in the same cycle
  // drops the byte.
  assign accept     = byte_valid_i && byte_ready_o && !start_i && !clear_i;
  assign is_cs_byte = (byte_cnt == CW'(N_BYTES));
  assign sh_clear   = clear_i || start_i;
  assign sh_shift   = accept && !is_cs_byte;

  lock_key_shreg #(
    .KEY_W(KEY_W)
  ) u_shreg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (sh_clear),
    .shift_i (sh_shift),
    .byte_i  (byte_i),
    .shadow_o(shadow),
    .acc_o   (acc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= LK_IDLE;
      byte_cnt     <= '0;
      timer        <= '0;
      chk_ok       <= 1'b0;
      byte_ready_o <= 1'b0;
      key_o        <= '0;
      key_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      error_o      <= 1'b0;
    end else if (clear_i) begin
      state        <= LK_IDLE;
      byte_cnt     <= '0;
      timer        <= '0;
      chk_ok       <= 1'b0;
      byte_ready_o <= 1'b0;
      key_o        <= '0;
      key_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      error_o      <= 1'b0;
    end else if (start_i) begin
      state        <= LK_LOAD;
      byte_cnt     <= '0;
      timer        <= '0;
      chk_ok       <= 1'b0;
      byte_ready_o <= 1'b1;
      key_o        <= '0;
      key_valid_o  <= 1'b0;
      busy_o       <= 1'b1;
      error_o      <= 1'b0;
    end else begin
      case (state)
        LK_LOAD: begin
          if (accept) begin
            timer <= '0;
            if (is_cs_byte) begin
              // Accumulator already holds the fold of all key bytes.
              chk_ok       <= (byte_i == acc);
              byte_ready_o <= 1'b0;
              state        <= LK_CHECK;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (timer == TW'(TIMEOUT)) begin
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            error_o      <= 1'b1;
            state        <= LK_ERROR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LK_CHECK: begin
          busy_o <= 1'b0;
          if (chk_ok) begin
            key_o       <= shadow;
            key_valid_o <= 1'b1;
            state       <= LK_ARMED;
          end else begin
            error_o <= 1'b1;
            state   <= LK_ERROR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_key_loader.sv
module tb_lock_key_loader;
  import lock_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        clear_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic [63:0] key_o;
  logic        key_valid_o;
  logic        busy_o;
  logic        error_o;

  typedef struct packed {
    logic [63:0] key;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam logic [63:0] KEY_A = 64'h192F7F0351667DEC;
  localparam logic [63:0] KEY_B = 64'h192F7F0351667DE8;

  lock_key_loader #(.KEY_W(64), .TIMEOUT(255)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .clear_i     (clear_i),
    .byte_i      (byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .key_o       (key_o),
    .key_valid_o (key_valid_o),
    .busy_o      (busy_o),
    .error_o     (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    byte_valid_i = 1'b1;
    byte_i       = b;
    tick();
    byte_valid_i = 1'b0;
  endtask

  task automatic send_key(input logic [63:0] key, input logic [7:0] cs, input int gap);
    for (int i = 0; i < 8; i++) send_byte(key[63-8*i -: 8], (i == 0) ? 0 : gap);
    send_byte(cs, gap);
  endtask

  task automatic wait_result(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!(key_valid_o || error_o) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(n < 20), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_key"}, key_o, e.key);
      chk({tag, "_valid"}, 64'(key_valid_o), 64'(e.valid));
      chk({tag, "_err"}, 64'(error_o), 64'(e.err));
    end else begin
      chk({tag, "_queue"}, 64'(exp_q.size()), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] rkey;
    rst_i = 1'b1; start_i = 1'b0; clear_i = 1'b0; byte_i = '0; byte_valid_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    chk("reset_key", key_o, 64'd0);
    chk("reset_flags", 64'({byte_ready_o, key_valid_o, busy_o, error_o}), 64'd0);

    // Golden load, one byte per cycle, with exact commit latency.
    pulse_start();
    chk("load_ready", 64'({byte_ready_o, busy_o}), 64'b11);
    exp_q.push_back('{key: KEY_A, valid: 1'b1, err: 1'b0});
    send_key(KEY_A, 8'hEC, 0);
    chk("check_cycle", 64'({key_valid_o, byte_ready_o, busy_o}), 64'b001);
    chk("check_key_hidden", key_o, 64'd0);
    tick();
    chk("latency_valid", 64'(key_valid_o), 64'd1);
    wait_result("golden");
    byte_valid_i = 1'b1; byte_i = 8'hAA;
    tick();
    byte_valid_i = 1'b0;
    chk("armed_ignore", key_o, KEY_A);
    chk("armed_ready", 64'(byte_ready_o), 64'd0);

    // Bad checksum.
    pulse_start();
    chk("restart_wipes", key_o, 64'd0);
    exp_q.push_back('{key: 64'd0, valid: 1'b0, err: 1'b1});
    send_key(KEY_A, 8'hED, 0);
    wait_result("badcs");

    // Gaps: 10 idle cycles between bytes, plus one 255-cycle gap (limit).
    pulse_start();
    chk("error_cleared", 64'(error_o), 64'd0);
    exp_q.push_back('{key: KEY_A, valid: 1'b1, err: 1'b0});
    for (int i = 0; i < 8; i++) send_byte(KEY_A[63-8*i -: 8], (i == 0) ? 0 : ((i == 4) ? 255 : 10));
    send_byte(8'hEC, 10);
    wait_result("gaps");

    // Timeout: 256 idle cycles after byte 3.
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(KEY_A[63-8*i -: 8], 0);
    repeat (255) tick();
    chk("timeout_edge_minus1", 64'({error_o, busy_o}), 64'b01);
    tick();
    chk("timeout_err", 64'({error_o, busy_o, byte_ready_o}), 64'b100);
    chk("timeout_key", key_o, 64'd0);

    // Restart mid-load; byte presented alongside start is dropped.
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(KEY_A[63-8*i -: 8], 0);
    byte_valid_i = 1'b1; byte_i = 8'h55;
    pulse_start();
    byte_valid_i = 1'b0;
    exp_q.push_back('{key: KEY_B, valid: 1'b1, err: 1'b0});
    send_key(KEY_B, 8'hE8, 0);
    wait_result("restart");

    // Random key, checksum built from the shared fold helper.
    rkey = {$urandom, $urandom};
    pulse_start();
    exp_q.push_back('{key: rkey, valid: 1'b1, err: 1'b0});
    send_key(rkey, xor_fold8(rkey), 2);
    wait_result("random");

    // Async reset while ARMED, between edges.
    #2 rst_i = 1'b1;
    #1;
    chk("rst_armed_key", key_o, 64'd0);
    chk("rst_armed_flags", 64'({byte_ready_o, key_valid_o, busy_o, error_o}), 64'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // Async reset mid-load.
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(KEY_A[63-8*i -: 8], 0);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_load_flags", 64'({byte_ready_o, key_valid_o, busy_o, error_o}), 64'd0);
    chk("rst_load_key", key_o, 64'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // clear_i beats start_i while ARMED.
    pulse_start();
    exp_q.push_back('{key: KEY_B, valid: 1'b1, err: 1'b0});
    send_key(KEY_B, 8'hE8, 0);
    wait_result("pre_clear");
    clear_i = 1'b1; start_i = 1'b1;
    tick();
    clear_i = 1'b0; start_i = 1'b0;
    chk("clear_key", key_o, 64'd0);
    chk("clear_flags", 64'({byte_ready_o, key_valid_o, busy_o, error_o}), 64'd0);
    // Still idle: bytes are not accepted.
    send_byte(8'h11, 0);
    chk("clear_idle", 64'({byte_ready_o, busy_o}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
